key_loader: RTL and testbench

//   Upstream key-ingest stage for the user_key XOR stage. Accepts the secret key
//   as a byte stream over a valid/ready handshake and assembles it MSB-first

---
 rtl/key_loader.sv | 95 +++++++++
 tb/tb_key_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/key_loader.sv
// Key ingest: assembles a KEY_W-bit key MSB-first from BYTE_W beats over valid/ready.
// Latency: key_valid rises 1 clock after the last accepted beat.
// Backpressure: byte_ready is high only while loading; optional rotation when KEY_ROTATE_EN is defined.
module key_loader #(
  parameter int KEY_W   = 32,
  parameter int BYTE_W  = 8,
  parameter int ROT_AMT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  input  logic              key_consume
);

  localparam int NBYTES = KEY_W / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [KEY_W-1:0]   shreg;
  logic [KEY_W-1:0]   assembled;
  logic [KEY_W-1:0]   key_rot;
  logic               accept;
  logic               last_beat;
  logic               rotate;

  // Word as it will look once the current beat is shifted in; also the final key on the last beat.
  assign assembled = {shreg[KEY_W-BYTE_W-1:0], byte_in};
  assign key_rot   = {key_out[KEY_W-ROT_AMT-1:0], key_out[KEY_W-1:KEY_W-ROT_AMT]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: load_start always restarts a load; the final beat moves to READY.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = LOAD;
      LOAD:    if (load_start) state_nxt = LOAD;
               else if (last_beat) state_nxt = READY;
      READY:   if (load_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-cycle decode: a beat coinciding with load_start is dropped, as is a consume.
  always_comb begin
    accept    = (state == LOAD) && byte_valid && byte_ready && !load_start;
    last_beat = accept && (cnt == CNT_W'(NBYTES - 1));
`ifdef KEY_ROTATE_EN
    rotate    = (state == READY) && key_consume && !load_start;
`else
    // Port kept for interface compatibility; it never affects the key here.
    rotate    = key_consume & 1'b0;
`endif
  end

  // Datapath: key_out only changes on load completion or rotation, never mid-load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      shreg      <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      byte_ready <= 1'b0;
    end else begin
      byte_ready <= (state_nxt == LOAD);
      if (load_start) begin
        cnt       <= '0;
        shreg     <= '0;
        key_valid <= 1'b0;
      end else if (accept) begin
        shreg <= assembled;
        cnt   <= cnt + 1'b1;
        if (last_beat) begin
          key_out   <= assembled;
          key_valid <= 1'b1;
        end
      end else if (rotate) begin
        key_out <= key_rot;
      end
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Testbench for key_loader: directed vector table plus randomized run against a reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are checked at the same point.
// Build with +define+KEY_ROTATE_EN to exercise the rotation variant.
module tb_key_loader;

  localparam int KEY_W  = 32;
  localparam int BYTE_W = 8;
  localparam int NB     = KEY_W / BYTE_W;
`ifdef KEY_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic [BYTE_W-1:0] byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              key_consume = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  key_loader #(.KEY_W(KEY_W), .BYTE_W(BYTE_W), .ROT_AMT(1)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .key_out(key_out),
    .key_valid(key_valid), .key_consume(key_consume)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         ls;
    bit         bv;
    bit [7:0]   b;
    bit         kc;
    bit [31:0]  key;
    bit         vld;
    bit         rdy;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a key, a valid flag, a "loading" flag and the bytes gathered so far.
  bit [31:0] m_key;
  bit        m_vld;
  bit        m_loading;
  bit [7:0]  m_bytes[$];

  task automatic add(input bit r, input bit ls, input bit bv, input bit [7:0] b, input bit kc,
                     input bit [31:0] key, input bit vld, input bit rdy);
    vec_t v;
    v.rst = r; v.ls = ls; v.bv = bv; v.b = b; v.kc = kc;
    v.key = key; v.vld = vld; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge given this cycle's inputs.
  task automatic model_step(input bit r, input bit ls, input bit bv, input bit [7:0] b, input bit kc);
    bit [31:0] w;
    if (r) begin
      m_key = 0; m_vld = 0; m_loading = 0; m_bytes.delete();
    end else if (ls) begin
      m_loading = 1; m_vld = 0; m_bytes.delete();
    end else if (m_loading && bv) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == NB) begin
        w = 0;
        foreach (m_bytes[i]) w = (w << 8) | 32'(m_bytes[i]);
        m_key = w; m_vld = 1; m_loading = 0; m_bytes.delete();
      end
    end else if (ROT_ON && m_vld && kc) begin
      m_key = (m_key << 1) | (m_key >> 31);
    end
  endtask

  task automatic drive(input bit r, input bit ls, input bit bv, input bit [7:0] b, input bit kc);
    rst = r; load_start = ls; byte_valid = bv; byte_in = b; key_consume = kc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [31:0] r1, r2;
    // 1: reset held two cycles
    add(1,0,0,8'h00,0, 32'h0,0,0);
    add(1,0,0,8'h00,0, 32'h0,0,0);
    // 2: back-to-back load of C0000003
    add(0,1,0,8'h00,0, 32'h0,0,1);
    add(0,0,1,8'hC0,0, 32'h0,0,1);
    add(0,0,1,8'h00,0, 32'h0,0,1);
    add(0,0,1,8'h00,0, 32'h0,0,1);
    add(0,0,1,8'h03,0, 32'hC0000003,1,0);
    add(0,0,0,8'h00,0, 32'hC0000003,1,0);
    // 5: two consumes
    r1 = ROT_ON ? 32'h80000007 : 32'hC0000003;
    r2 = ROT_ON ? 32'h0000000F : 32'hC0000003;
    add(0,0,0,8'h00,1, r1,1,0);
    add(0,0,0,8'h00,1, r2,1,0);
    add(0,0,0,8'h00,0, r2,1,0);
    // 3: beats and consume ignored in IDLE; beat with load_start dropped; gaps during load
    add(1,0,0,8'h00,0, 32'h0,0,0);
    add(0,0,1,8'hFF,1, 32'h0,0,0);
    add(0,1,1,8'hFF,0, 32'h0,0,1);
    add(0,0,1,8'h12,0, 32'h0,0,1);
    add(0,0,0,8'hEE,0, 32'h0,0,1);
    add(0,0,1,8'h34,0, 32'h0,0,1);
    add(0,0,0,8'hEE,0, 32'h0,0,1);
    add(0,0,1,8'h56,0, 32'h0,0,1);
    add(0,0,0,8'hEE,0, 32'h0,0,1);
    add(0,0,1,8'h78,0, 32'h12345678,1,0);
    // 4: restart mid-load; old key held until the new one completes
    add(0,1,0,8'h00,0, 32'h12345678,0,1);
    add(0,0,1,8'hAA,0, 32'h12345678,0,1);
    add(0,0,1,8'hBB,0, 32'h12345678,0,1);
    add(0,1,1,8'hCC,0, 32'h12345678,0,1);
    add(0,0,1,8'h11,1, 32'h12345678,0,1);
    add(0,0,1,8'h22,0, 32'h12345678,0,1);
    add(0,0,1,8'h33,0, 32'h12345678,0,1);
    add(0,0,1,8'h44,0, 32'h11223344,1,0);
    // load_start beats key_consume: no rotation
    add(0,1,0,8'h00,1, 32'h11223344,0,1);
    // 6: reset after three beats, then a fresh load
    add(0,0,1,8'hDE,0, 32'h11223344,0,1);
    add(0,0,1,8'hAD,0, 32'h11223344,0,1);
    add(0,0,1,8'hBE,0, 32'h11223344,0,1);
    add(1,0,1,8'hEF,0, 32'h0,0,0);
    add(0,1,0,8'h00,0, 32'h0,0,1);
    add(0,0,1,8'hDE,0, 32'h0,0,1);
    add(0,0,1,8'hAD,0, 32'h0,0,1);
    add(0,0,1,8'hBE,0, 32'h0,0,1);
    add(0,0,1,8'hEF,0, 32'hDEADBEEF,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ls, vecs[i].bv, vecs[i].b, vecs[i].kc);
      check($sformatf("vec%0d key_out", i), key_out, vecs[i].key);
      check($sformatf("vec%0d key_valid", i), 32'(key_valid), 32'(vecs[i].vld));
      check($sformatf("vec%0d byte_ready", i), 32'(byte_ready), 32'(vecs[i].rdy));
    end

    // Randomized run against the reference model, starting from reset.
    for (int c = 0; c < 3000; c++) begin
      bit r, ls, bv, kc;
      bit [7:0] b;
      r  = (c == 0) || ($urandom_range(63) == 0);
      ls = ($urandom_range(15) == 0);
      bv = $urandom_range(1);
      kc = ($urandom_range(3) == 0);
      b  = 8'($urandom);
      model_step(r, ls, bv, b, kc);
      drive(r, ls, bv, b, kc);
      check($sformatf("rnd%0d key_out", c), key_out, m_key);
      check($sformatf("rnd%0d key_valid", c), 32'(key_valid), 32'(m_vld));
      check($sformatf("rnd%0d byte_ready", c), 32'(byte_ready), 32'(m_loading));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
